// File: rtl/frame_serializer.sv
// rtl/frame_serializer.sv - framed serial line generator: preamble ones, MSB-first payload words, zero gap; PRBS7 payload option under FS_PRBS_EN
module frame_serializer #(
    parameter int PREAMBLE_LEN = 10,
    parameter int WORD_W       = 10,
    parameter int FRAME_WORDS  = 720,
    parameter int GAP_CYCLES   = 200
) (
    input  logic              CLK_30MHz,
    input  logic              RSTN,
    input  logic              START,
    input  logic [WORD_W-1:0] WORD_IN,
    input  logic              WORD_VALID,
    output logic              WORD_READY,
    input  logic              PRBS_SEL,
    output logic              DOUT,
    output logic              BUSY,
    output logic              FRAME_DONE,
    output logic              UNDERRUN
);
    localparam int PRE_W   = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
    localparam int BIT_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int WORD_CW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(PREAMBLE_LEN - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST  = BIT_W'(WORD_W - 1);
    localparam logic [WORD_CW-1:0] WORD_LAST = WORD_CW'(FRAME_WORDS - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_PAY,
        S_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WORD_CW-1:0]  word_cnt_q, word_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic                dout_q, dout_d;
    logic                frame_done_q, frame_done_d;
    logic                underrun_q, underrun_d;

    logic                pre_last;
    logic                bit_last;
    logic                word_last;
    logic                gap_last;
    logic                word_ready_c;
    logic                prbs_mode;
    logic [WORD_W-1:0]   load_word;

`ifdef FS_PRBS_EN
    logic [6:0]          prbs_q, prbs_d;
    assign prbs_mode = PRBS_SEL;
`else
    logic                unused_prbs_sel;
    assign unused_prbs_sel = PRBS_SEL;
    assign prbs_mode       = 1'b0;
`endif

    assign pre_last  = (pre_cnt_q == PRE_LAST);
    assign bit_last  = (bit_cnt_q == BIT_LAST);
    assign word_last = (word_cnt_q == WORD_LAST);
    assign gap_last  = (gap_cnt_q == GAP_LAST);

    // A word is fetched one cycle ahead of need: on the last preamble bit and on the last bit of every word but the final one
    assign word_ready_c = !prbs_mode &&
                          (((state_q == S_PRE) && pre_last) ||
                           ((state_q == S_PAY) && bit_last && !word_last));
    assign load_word    = WORD_VALID ? WORD_IN : '0;

    assign WORD_READY = word_ready_c;
    assign DOUT       = dout_q;
    assign BUSY       = (state_q != S_IDLE);
    assign FRAME_DONE = frame_done_q;
    assign UNDERRUN   = underrun_q;

    // Next-state, counters, shift register and the next registered line bit
    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        shreg_d    = shreg_q;
        underrun_d = underrun_q;
        dout_d     = 1'b0;
`ifdef FS_PRBS_EN
        prbs_d     = prbs_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d    = S_PRE;
                    pre_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    gap_cnt_d  = '0;
                    underrun_d = 1'b0;
                    dout_d     = 1'b1;
`ifdef FS_PRBS_EN
                    prbs_d     = 7'h7F;
`endif
                end
            end
            S_PRE: begin
                dout_d = 1'b1;
                if (pre_last) begin
                    state_d   = S_PAY;
                    pre_cnt_d = '0;
                end else begin
                    pre_cnt_d = pre_cnt_q + PRE_W'(1);
                end
            end
            S_PAY: begin
                shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
                if (bit_last) begin
                    bit_cnt_d = '0;
                    if (word_last) begin
                        state_d    = S_GAP;
                        word_cnt_d = '0;
                        gap_cnt_d  = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + WORD_CW'(1);
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            S_GAP: begin
                if (gap_last) begin
                    state_d   = S_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (word_ready_c) begin
            shreg_d = load_word;
            if (!WORD_VALID) begin
                underrun_d = 1'b1;
            end
        end

        // DOUT is registered, so the bit for the coming payload cycle is chosen from the next shift value
        if (state_d == S_PAY) begin
            dout_d = shreg_d[WORD_W-1];
`ifdef FS_PRBS_EN
            if (prbs_mode) begin
                dout_d = prbs_q[6];
                prbs_d = {prbs_q[5:0], prbs_q[6] ^ prbs_q[5]};
            end
`endif
        end

        frame_done_d = (state_d == S_GAP) && (gap_cnt_d == GAP_LAST);
    end

    // State and output registers; reset forces the line low at once and abandons any frame in flight
    always_ff @(posedge CLK_30MHz or negedge RSTN) begin
        if (!RSTN) begin
            state_q      <= S_IDLE;
            pre_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            shreg_q      <= '0;
            dout_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
`ifdef FS_PRBS_EN
            prbs_q       <= 7'h7F;
`endif
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            shreg_q      <= shreg_d;
            dout_q       <= dout_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
`ifdef FS_PRBS_EN
            prbs_q       <= prbs_d;
`endif
        end
    end

endmodule

// File: tb/tb_frame_serializer.sv
// tb/tb_frame_serializer.sv - self-checking bench for frame_serializer
module tb_frame_serializer;
    localparam int PRE  = 10;
    localparam int W    = 10;
    localparam int NW   = 720;
    localparam int GAP  = 200;
    localparam int PAYB = NW * W;
    localparam int FLEN = PRE + PAYB + GAP;
`ifdef FS_PRBS_EN
    localparam bit PRBS_BUILD = 1'b1;
`else
    localparam bit PRBS_BUILD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstn;
    logic         start;
    logic         prbs_sel;
    logic [W-1:0] word_in = '0;
    logic         word_valid = 1'b0;
    logic         word_ready, dout, busy, frame_done, underrun;

    frame_serializer #(
        .PREAMBLE_LEN(PRE),
        .WORD_W      (W),
        .FRAME_WORDS (NW),
        .GAP_CYCLES  (GAP)
    ) dut (
        .CLK_30MHz (clk),
        .RSTN      (rstn),
        .START     (start),
        .WORD_IN   (word_in),
        .WORD_VALID(word_valid),
        .WORD_READY(word_ready),
        .PRBS_SEL  (prbs_sel),
        .DOUT      (dout),
        .BUSY      (busy),
        .FRAME_DONE(frame_done),
        .UNDERRUN  (underrun)
    );

    always #16 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: pos is the position inside the frame of the current cycle, -1 when idle
    int         pos = -1;
    logic [W-1:0] words [NW];
    bit         exp_underrun = 1'b0;
    bit         prbs_mode = 1'b0;
    logic [6:0] prbs_r = 7'h7F;
    bit         line [FLEN];
    int         src_k = 0;
    int         dut_hs = 0;
    int         done_count = 0;
    int         cycle = 0;
    int         done_cyc [$];
    int         busy_run = 0;
    int         last_busy_len = 0;
    int         drop_word_cfg = -1;
    int         drop_word_act = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_ready_f(input int p, input bit pm);
        if (pm) return 1'b0;
        return (p == PRE - 1) || (p >= PRE && p < PRE + PAYB - W && (p - PRE) % W == W - 1);
    endfunction

    function automatic logic [31:0] line_bits(input int from, input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = {v[30:0], line[from + i]};
        return v;
    endfunction

    // compare DUT against the model every cycle, then step the model over the coming edge
    always @(negedge clk) begin
        logic e_dout;
        int   idx;
        cycle++;
        if (!rstn) begin
            pos          = -1;
            exp_underrun = 1'b0;
            busy_run     = 0;
        end
        if (pos < 0)              e_dout = 1'b0;
        else if (pos < PRE)       e_dout = 1'b1;
        else if (pos < PRE + PAYB) e_dout = prbs_mode ? prbs_r[6] : words[(pos - PRE) / W][W - 1 - (pos - PRE) % W];
        else                      e_dout = 1'b0;
        check("dout", dout, e_dout);
        check("word_ready", word_ready, exp_ready_f(pos, prbs_mode));
        check("busy", busy, pos >= 0);
        check("frame_done", frame_done, pos == FLEN - 1);
        check("underrun", underrun, exp_underrun);

        if (pos >= 0) line[pos] = dout;
        if (frame_done) begin
            done_count++;
            done_cyc.push_back(cycle);
        end
        if (busy) busy_run++;
        else if (busy_run > 0) begin
            last_busy_len = busy_run;
            busy_run      = 0;
        end
        if (rstn && word_ready) begin
            if (word_valid) begin
                src_k++;
                dut_hs++;
            end else if (drop_word_act == src_k) begin
                drop_word_act = -1;
            end
        end

        if (rstn) begin
            if (pos < 0) begin
                if (start) begin
                    pos           = 0;
                    exp_underrun  = 1'b0;
                    src_k         = 0;
                    dut_hs        = 0;
                    prbs_r        = 7'h7F;
                    prbs_mode     = PRBS_BUILD && prbs_sel;
                    drop_word_act = drop_word_cfg;
                end
            end else begin
                if (exp_ready_f(pos, prbs_mode)) begin
                    idx = (pos == PRE - 1) ? 0 : (pos - PRE) / W + 1;
                    if (word_valid) words[idx] = word_in;
                    else begin
                        words[idx]   = '0;
                        exp_underrun = 1'b1;
                    end
                end
                if (prbs_mode && pos >= PRE && pos < PRE + PAYB)
                    prbs_r = {prbs_r[5:0], prbs_r[6] ^ prbs_r[5]};
                pos++;
                if (pos == FLEN) pos = -1;
            end
        end
    end

    // source: word k = k mod 1024, held until taken; VALID withheld for the selected word
    always @(posedge clk) begin
        #1;
        word_in    = W'(src_k % 1024);
        word_valid = !(drop_word_act >= 0 && drop_word_act == src_k);
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        int target;
        target = done_count + n;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done_count >= target) return;
        end
        check("frame_done_timeout", done_count, target);
    endtask

    initial begin
        int n;
        int ones;
        bit found;
        rstn     = 1'b1;
        start    = 1'b0;
        prbs_sel = 1'b0;
        #1 rstn  = 1'b0;

        // T1 reset
        repeat (5) @(posedge clk);
        #1;
        check("rst_dout", dout, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", word_ready, 0);
        check("rst_done", frame_done, 0);
        check("rst_underrun", underrun, 0);
        rstn = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("idle_dout", dout, 0);
        check("idle_busy", busy, 0);

        // T2 basic frame
        n = done_count;
        pulse_start();
        wait_done(1, FLEN + 50);
        repeat (3) @(posedge clk);
        #1;
        check("t2_done_count", done_count - n, 1);
        check("t2_handshakes", dut_hs, 720);
        check("t2_preamble", line_bits(0, 10), 32'h3FF);
        check("t2_word0", line_bits(10, 10), 0);
        check("t2_word1", line_bits(20, 10), 32'b0000000001);
        check("t2_word719", line_bits(7200, 10), 32'b1011001111);
        ones = 0;
        for (int i = PRE + PAYB; i < FLEN; i++) ones += int'(line[i]);
        check("t2_gap_zeros", ones, 0);
        check("t2_frame_len", last_busy_len, FLEN);

        // T3 underrun on word 5
        drop_word_cfg = 5;
        pulse_start();
        drop_word_cfg = -1;
        wait_done(1, FLEN + 50);
        repeat (3) @(posedge clk);
        #1;
        check("t3_word5_zero", line_bits(60, 10), 0);
        check("t3_word6_retry", line_bits(70, 10), 5);
        check("t3_word719", line_bits(7200, 10), 718);
        check("t3_handshakes", dut_hs, 719);
        check("t3_underrun_sticky", underrun, 1);
        check("t3_frame_len", last_busy_len, FLEN);

        // T4 back to back with START held
        n = done_count;
        start = 1'b1;
        @(posedge clk); #1;
        check("t4_underrun_cleared", underrun, 0);
        wait_done(3, 3 * (FLEN + 1) + 50);
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("t4_done_count", done_count - n, 3);
        if (done_cyc.size() >= 3) begin
            check("t4_spacing_a", done_cyc[done_cyc.size() - 2] - done_cyc[done_cyc.size() - 3], FLEN + 1);
            check("t4_spacing_b", done_cyc[done_cyc.size() - 1] - done_cyc[done_cyc.size() - 2], FLEN + 1);
        end
        check("t4_idle_after", busy, 0);

        // T5 reset in the middle of the payload
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < FLEN; i++) begin
            if (pos == PRE + 3001) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("t5_reached_bit", found, 1);
        check("t5_dout_before", dout, 1);
        #2 rstn = 1'b0;
        #1;
        check("t5_dout_async", dout, 0);
        check("t5_busy_async", busy, 0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("t5_still_idle", busy, 0);
        n = done_count;
        pulse_start();
        wait_done(1, FLEN + 50);
        repeat (3) @(posedge clk);
        #1;
        check("t5_done_count", done_count - n, 1);
        check("t5_handshakes", dut_hs, 720);
        check("t5_word1", line_bits(20, 10), 32'b0000000001);
        check("t5_frame_len", last_busy_len, FLEN);

`ifdef FS_PRBS_EN
        // T6 PRBS payload
        prbs_sel = 1'b1;
        pulse_start();
        wait_done(1, FLEN + 50);
        repeat (3) @(posedge clk);
        #1;
        check("t6_prbs_head", line_bits(10, 14), 32'b11111110000001);
        check("t6_handshakes", dut_hs, 0);
        check("t6_underrun", underrun, 0);
        prbs_sel = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
